// File: rtl/cpu6_ifu_ibuf_pkg.sv
// Shared cpu6 fetch-path constants and address helpers.
// Also used by cpu6_sync_fifo users elsewhere in the core.
package cpu6_ifu_ibuf_pkg;

  localparam int CPU6_XLEN       = 32;
  localparam int CPU6_INSTR_SIZE = 32;
  localparam logic [CPU6_XLEN-1:0] CPU6_RESET_PC = '0;
  localparam logic [CPU6_XLEN-1:0] CPU6_PC_INC   = 32'd4;

  // Fetch addresses are always word aligned; low bits of a target are discarded.
  function automatic logic [CPU6_XLEN-1:0] word_align(input logic [CPU6_XLEN-1:0] addr);
    return {addr[CPU6_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu6_sync_fifo.sv
// First-word fall-through synchronous FIFO with flush and occupancy count.
// Push while full is accepted only when a pop frees the head slot in the same cycle.
module cpu6_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage has no reset; stale contents are never visible because count gates validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/cpu6_ifu_ibuf.sv
// cpu6 fetch-address generator and instruction buffer feeding decode.
// Credits keep buffered plus live in-flight words within DEPTH, so responses never overflow.
module cpu6_ifu_ibuf
  import cpu6_ifu_ibuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [CPU6_XLEN-1:0] RESET_PC = CPU6_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ifu_req_valid,
  output logic [CPU6_XLEN-1:0]       ifu_req_addr,
  input  logic                       ifu_req_ready,
  input  logic                       ifu_rsp_valid,
  input  logic [CPU6_INSTR_SIZE-1:0] ifu_rsp_instr,
  input  logic                       redirect_valid,
  input  logic [CPU6_XLEN-1:0]       redirect_pc,
  output logic                       dec_valid,
  output logic [CPU6_INSTR_SIZE-1:0] dec_instr,
  output logic [CPU6_XLEN-1:0]       dec_pc,
  input  logic                       dec_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [CPU6_XLEN-1:0]       fetch_pc_reg;
  logic [CPU6_XLEN-1:0]       head_pc_reg;
  logic [CW-1:0]              outstanding_reg;
  logic [CW-1:0]              outstanding_next;
  logic [CW-1:0]              drop_reg;
  logic [CW-1:0]              drop_next;
  logic [CW-1:0]              fifo_count;
  logic                       fifo_empty;
  logic [CPU6_INSTR_SIZE-1:0] head_instr;
  logic [CW:0]                credit_used;
  logic                       req_fire;
  logic                       rsp_keep;
  logic                       fifo_pop;

  // One extra bit: count+outstanding may exceed DEPTH while stale words are pending drop.
  assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding_reg} - {1'b0, drop_reg};
  assign ifu_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_W);
  assign ifu_req_addr  = fetch_pc_reg;
  assign req_fire      = ifu_req_valid && ifu_req_ready;
  assign rsp_keep      = ifu_rsp_valid && (drop_reg == '0) && !redirect_valid;
  assign fifo_pop      = dec_valid && dec_ready && !redirect_valid;

  always_comb begin
    outstanding_next = outstanding_reg;
    if (req_fire && !ifu_rsp_valid)      outstanding_next = outstanding_reg + 1'b1;
    else if (!req_fire && ifu_rsp_valid) outstanding_next = outstanding_reg - 1'b1;

    drop_next = drop_reg;
    if (redirect_valid)                        drop_next = outstanding_next;
    else if (ifu_rsp_valid && drop_reg != '0) drop_next = drop_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      head_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      if (redirect_valid) begin
        fetch_pc_reg <= word_align(redirect_pc);
        head_pc_reg  <= word_align(redirect_pc);
      end else begin
        if (req_fire) fetch_pc_reg <= fetch_pc_reg + CPU6_PC_INC;
        if (fifo_pop) head_pc_reg  <= head_pc_reg + CPU6_PC_INC;
      end
    end
  end

  cpu6_sync_fifo #(
    .WIDTH (CPU6_INSTR_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data (ifu_rsp_instr),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_data (head_instr),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Decode outputs are forced to reset values combinationally while reset is held.
  assign dec_valid = !reset && !fifo_empty;
  assign dec_instr = reset ? '0 : head_instr;
  assign dec_pc    = reset ? RESET_PC : head_pc_reg;

endmodule
